noc_resp_tx: RTL and testbench

//  Response transmitter on the NoC return path (CmdR/DataR), consuming the completed requests of the

---
 rtl/noc_resp_tx_if.sv | 26 ++
 rtl/noc_resp_tx.sv | 112 +++++++++++
 tb/tb_noc_resp_tx.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/noc_resp_tx_if.sv
// Request and payload handshake bundle between the command parser and the response transmitter.
// The master side presents requests and payload bytes; the slave side (transmitter) pulls them.
interface noc_resp_tx_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_type;
  logic [7:0] req_return_id;
  logic       req_err;
  logic [2:0] req_err_code;
  logic [7:0] req_len;
  logic       data_valid;
  logic       data_ready;
  logic [7:0] data_in;

  modport master (
    output req_valid, req_type, req_return_id, req_err, req_err_code, req_len,
    output data_valid, data_in,
    input  req_ready, data_ready
  );

  modport slave (
    input  req_valid, req_type, req_return_id, req_err, req_err_code, req_len,
    input  data_valid, data_in,
    output req_ready, data_ready
  );
endinterface

// File: rtl/noc_resp_tx.sv
// NoC response transmitter: serialises READ/WRITE_RESPONSE packets onto the 9-bit {ale,cmd} bus,
// inserting IDLE fillers while payload is late and aborting with END after too many fillers.
module noc_resp_tx #(
  parameter int unsigned DATA_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  noc_resp_tx_if.slave bus,
  output logic        ale_out,
  output logic [7:0]  cmd_out,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] tx_pkt_count
);

  localparam logic [7:0] WaitMax = 8'(DATA_WAIT_MAX);

  typedef enum logic [2:0] {
    StIdle,
    StRid,
    StLen,
    StData,
    StEnd
  } state_e;

  state_e     state_q;
  logic       type_q;
  logic [7:0] rid_q;
  logic [7:0] len_q;
  logic [7:0] remaining_q;
  logic [7:0] wait_q;
  logic       accept;
  logic       data_hs;

  // Handshakes are held off while reset is asserted.
  assign bus.req_ready  = (state_q == StIdle) & ~rst;
  assign bus.data_ready = (state_q == StData) & (wait_q < WaitMax) & ~rst;
  assign accept         = bus.req_valid & bus.req_ready;
  assign data_hs        = bus.data_valid & bus.data_ready;
  assign busy           = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ale_out      <= 1'b1;
      cmd_out      <= 8'h00;
      underrun     <= 1'b0;
      tx_pkt_count <= 16'h0000;
      type_q       <= 1'b0;
      rid_q        <= 8'h00;
      len_q        <= 8'h00;
      remaining_q  <= 8'h00;
      wait_q       <= 8'h00;
    end else begin
      underrun <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ale_out <= 1'b1;
          cmd_out <= 8'h00;
          if (accept) begin
            type_q  <= bus.req_type;
            rid_q   <= bus.req_return_id;
            // Errored responses carry no payload, so the length byte is forced to zero.
            len_q   <= bus.req_err ? 8'h00 : bus.req_len;
            cmd_out <= {(bus.req_type ? 2'b10 : 2'b01), 2'b00, bus.req_err, bus.req_err_code};
            state_q <= StRid;
          end
        end
        StRid: begin
          ale_out <= 1'b0;
          cmd_out <= rid_q;
          state_q <= type_q ? StEnd : StLen;
        end
        StLen: begin
          ale_out     <= 1'b0;
          cmd_out     <= len_q;
          remaining_q <= len_q;
          wait_q      <= 8'h00;
          state_q     <= (len_q == 8'h00) ? StEnd : StData;
        end
        StData: begin
          if (data_hs) begin
            ale_out     <= 1'b0;
            cmd_out     <= bus.data_in;
            remaining_q <= remaining_q - 8'd1;
            wait_q      <= 8'h00;
            if (remaining_q == 8'd1) state_q <= StEnd;
          end else if (wait_q < WaitMax) begin
            ale_out <= 1'b1;
            cmd_out <= 8'h00;
            wait_q  <= wait_q + 8'd1;
          end else begin
            // Starved: close the packet now; unsent payload bytes are left unconsumed.
            ale_out      <= 1'b1;
            cmd_out      <= 8'hE0;
            underrun     <= 1'b1;
            tx_pkt_count <= tx_pkt_count + 16'd1;
            state_q      <= StIdle;
          end
        end
        StEnd: begin
          ale_out      <= 1'b1;
          cmd_out      <= 8'hE0;
          tx_pkt_count <= tx_pkt_count + 16'd1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_resp_tx.sv
// Directed bench for noc_resp_tx: checks token streams, filler insertion, starvation abort,
// errored reads, back-to-back packets and asynchronous reset.
module tb_noc_resp_tx;

  logic        clk;
  logic        rst;
  logic        ale_out;
  logic [7:0]  cmd_out;
  logic        busy;
  logic        underrun;
  logic [15:0] tx_pkt_count;
  logic [8:0]  tok;

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int und_cnt = 0;

  noc_resp_tx_if bus ();

  noc_resp_tx #(.DATA_WAIT_MAX(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .ale_out      (ale_out),
    .cmd_out      (cmd_out),
    .busy         (busy),
    .underrun     (underrun),
    .tx_pkt_count (tx_pkt_count)
  );

  assign tok = {ale_out, cmd_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && bus.data_valid && bus.data_ready) hs_cnt <= hs_cnt + 1;
    if (underrun) und_cnt <= und_cnt + 1;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge; afterwards the command token is visible.
  task automatic start_req(input logic typ, input logic [7:0] rid, input logic err,
                           input logic [2:0] code, input logic [7:0] len);
    bus.req_type      = typ;
    bus.req_return_id = rid;
    bus.req_err       = err;
    bus.req_err_code  = code;
    bus.req_len       = len;
    bus.req_valid     = 1'b1;
    chk("req_ready_idle", {15'd0, bus.req_ready}, 16'd1);
    step();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    rst               = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_type      = 1'b0;
    bus.req_return_id = 8'h00;
    bus.req_err       = 1'b0;
    bus.req_err_code  = 3'd0;
    bus.req_len       = 8'h00;
    bus.data_valid    = 1'b0;
    bus.data_in       = 8'h00;
    #1;
    chk("rst_tok", {7'd0, tok}, 16'h0100);
    chk("rst_req_ready", {15'd0, bus.req_ready}, 16'd0);
    chk("rst_data_ready", {15'd0, bus.data_ready}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_count", tx_pkt_count, 16'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("idle_tok", {7'd0, tok}, 16'h0100);

    // Read, rid 5A, three bytes always valid.
    bus.data_valid = 1'b1;
    bus.data_in    = 8'hA1;
    start_req(1'b0, 8'h5A, 1'b0, 3'd0, 8'd3);
    chk("t2_cmd", {7'd0, tok}, 16'h0140);
    chk("t2_busy", {15'd0, busy}, 16'd1);
    step(); chk("t2_rid", {7'd0, tok}, 16'h005A);
    step(); chk("t2_len", {7'd0, tok}, 16'h0003);
    step(); chk("t2_d0", {7'd0, tok}, 16'h00A1);
    bus.data_in = 8'hA2;
    step(); chk("t2_d1", {7'd0, tok}, 16'h00A2);
    bus.data_in = 8'hA3;
    step(); chk("t2_d2", {7'd0, tok}, 16'h00A3);
    step(); chk("t2_end", {7'd0, tok}, 16'h01E0);
    bus.data_valid = 1'b0;
    step(); chk("t2_idle", {7'd0, tok}, 16'h0100);
    chk("t2_count", tx_pkt_count, 16'd1);
    chk("t2_hs", 16'(hs_cnt), 16'd3);

    // Errored write response; payload offered but must never be taken.
    bus.data_valid = 1'b1;
    start_req(1'b1, 8'h33, 1'b1, 3'd5, 8'd7);
    chk("t3_cmd", {7'd0, tok}, 16'h018D);
    chk("t3_dr0", {15'd0, bus.data_ready}, 16'd0);
    step(); chk("t3_rid", {7'd0, tok}, 16'h0033);
    chk("t3_dr1", {15'd0, bus.data_ready}, 16'd0);
    step(); chk("t3_end", {7'd0, tok}, 16'h01E0);
    bus.data_valid = 1'b0;
    step();
    chk("t3_count", tx_pkt_count, 16'd2);
    chk("t3_hs", 16'(hs_cnt), 16'd3);

    // Read len 2 with a two-cycle gap before the second byte.
    bus.data_valid = 1'b1;
    bus.data_in    = 8'hD0;
    start_req(1'b0, 8'h11, 1'b0, 3'd0, 8'd2);
    chk("t4_cmd", {7'd0, tok}, 16'h0140);
    step(); chk("t4_rid", {7'd0, tok}, 16'h0011);
    step(); chk("t4_len", {7'd0, tok}, 16'h0002);
    step(); chk("t4_d0", {7'd0, tok}, 16'h00D0);
    bus.data_valid = 1'b0;
    step(); chk("t4_fill0", {7'd0, tok}, 16'h0100);
    step(); chk("t4_fill1", {7'd0, tok}, 16'h0100);
    bus.data_valid = 1'b1;
    bus.data_in    = 8'hD1;
    step(); chk("t4_d1", {7'd0, tok}, 16'h00D1);
    bus.data_valid = 1'b0;
    step(); chk("t4_end", {7'd0, tok}, 16'h01E0);
    chk("t4_no_underrun", {15'd0, underrun}, 16'd0);
    step();
    chk("t4_count", tx_pkt_count, 16'd3);
    chk("t4_und_cnt", 16'(und_cnt), 16'd0);

    // Read len 2 with no data at all: 15 fillers then abort.
    start_req(1'b0, 8'h22, 1'b0, 3'd0, 8'd2);
    chk("t5_cmd", {7'd0, tok}, 16'h0140);
    step(); chk("t5_rid", {7'd0, tok}, 16'h0022);
    step(); chk("t5_len", {7'd0, tok}, 16'h0002);
    for (int i = 0; i < 15; i++) begin
      step(); chk("t5_fill", {7'd0, tok}, 16'h0100);
    end
    step(); chk("t5_end", {7'd0, tok}, 16'h01E0);
    chk("t5_underrun", {15'd0, underrun}, 16'd1);
    chk("t5_count", tx_pkt_count, 16'd4);
    step(); chk("t5_idle", {7'd0, tok}, 16'h0100);
    chk("t5_und_clr", {15'd0, underrun}, 16'd0);
    chk("t5_und_cnt", 16'(und_cnt), 16'd1);
    chk("t5_busy", {15'd0, busy}, 16'd0);

    // Errored read: zero length, no consumption, then a back-to-back write.
    bus.data_valid = 1'b1;
    bus.data_in    = 8'h77;
    start_req(1'b0, 8'h44, 1'b1, 3'd2, 8'd4);
    chk("t6_cmd", {7'd0, tok}, 16'h014A);
    step(); chk("t6_rid", {7'd0, tok}, 16'h0044);
    step(); chk("t6_len", {7'd0, tok}, 16'h0000);
    step(); chk("t6_end", {7'd0, tok}, 16'h01E0);
    start_req(1'b1, 8'h55, 1'b0, 3'd0, 8'd0);
    chk("t6_b2b_cmd", {7'd0, tok}, 16'h0180);
    step(); chk("t6_b2b_rid", {7'd0, tok}, 16'h0055);
    step(); chk("t6_b2b_end", {7'd0, tok}, 16'h01E0);
    bus.data_valid = 1'b0;
    step();
    chk("t6_count", tx_pkt_count, 16'd6);
    chk("t6_hs", 16'(hs_cnt), 16'd5);

    // Asynchronous reset in the middle of a packet.
    start_req(1'b0, 8'h66, 1'b0, 3'd0, 8'd1);
    chk("t1_cmd", {7'd0, tok}, 16'h0140);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_tok", {7'd0, tok}, 16'h0100);
    chk("t1_busy", {15'd0, busy}, 16'd0);
    chk("t1_count", tx_pkt_count, 16'd0);
    chk("t1_req_ready", {15'd0, bus.req_ready}, 16'd0);
    step();
    rst = 1'b0;
    #1;
    chk("t1_release_ready", {15'd0, bus.req_ready}, 16'd1);
    step();
    chk("t1_idle_tok", {7'd0, tok}, 16'h0100);
    chk("t1_idle_count", tx_pkt_count, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
